// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;

  // IDLE: nothing outstanding, BUSY: response kept, DROP: response discarded.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low bits of a target are ignored.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_buffer.sv
// Two-entry {PC, instr} FIFO between fetch and decode.
module if_fetch_buffer
  import if_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic [XLEN-1:0] push_instr_i,
  input  logic            pop_i,
  input  logic            flush_younger_i,
  output logic [1:0]      count_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_instr_o
);

  fetch_entry_t ent_q [2];
  fetch_entry_t ent_d [2];
  logic [1:0]   count_q, count_d;
  logic [1:0]   kept;

  // Pop, then drop younger entries on flush, then append the push.
  always_comb begin
    ent_d = ent_q;
    kept  = count_q;
    if (pop_i && count_q != 2'd0) begin
      ent_d[0] = ent_q[1];
      kept     = count_q - 2'd1;
    end
    if (flush_younger_i) begin
      // Only an unpopped head survives a flush.
      kept = (pop_i || count_q == 2'd0) ? 2'd0 : 2'd1;
    end
    count_d = kept;
    if (push_i && kept != 2'd2) begin
      if (kept == 2'd0) begin
        ent_d[0] = '{pc: push_pc_i, instr: push_instr_i};
      end else begin
        ent_d[1] = '{pc: push_pc_i, instr: push_instr_i};
      end
      count_d = kept + 2'd1;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      count_q  <= 2'd0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  // Head is forced to a nop at PC 0 when empty.
  always_comb begin
    count_o      = count_q;
    head_pc_o    = (count_q != 2'd0) ? ent_q[0].pc    : '0;
    head_instr_o = (count_q != 2'd0) ? ent_q[0].instr : NOP_WORD;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: owns the fetch PC, drives a one-outstanding imem port and
// feeds ID through a 2-entry buffer while honouring the branch delay slot.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_ID,
  input  logic            branch_jump,
  input  logic [XLEN-1:0] bj_address,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_IF,
  output logic [XLEN-1:0] PC_IF,
  output logic            valid_IF
);

  fetch_state_e    state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;

  logic [1:0]      buf_count;
  logic [1:0]      occ_after;
  logic            buf_empty, ack, pop, redirect, flush_younger, push;
  logic            free_after, issue;
  logic [XLEN-1:0] target, fpc_eff, pend_addr_eff;
  logic            pend_valid_eff;

  assign target        = word_align(bj_address);
  assign buf_empty     = (buf_count == 2'd0);
  assign valid_IF      = !buf_empty;
  assign ack           = imem_ack && req_q;
  assign pop           = valid_IF && !stall_ID;
  assign redirect      = branch_jump && !stall_ID;
  // Head pops as the delay slot; anything behind it is wrong-path.
  assign flush_younger = redirect && !buf_empty;
  // An ack landing while the head is the delay slot is wrong-path too.
  assign push          = ack && (state_q == StBusy) && !flush_younger;

  // Redirect bookkeeping: if fetch_pc itself is the delay slot the target
  // waits in the pending register, otherwise it replaces fetch_pc now.
  always_comb begin
    fpc_eff        = fetch_pc_q;
    pend_valid_eff = pend_valid_q;
    pend_addr_eff  = pend_addr_q;
    if (redirect) begin
      if (buf_empty && state_q == StIdle) begin
        pend_valid_eff = 1'b1;
        pend_addr_eff  = target;
      end else begin
        fpc_eff = target;
      end
    end
  end

  // Issue only with the port free after this edge and room for the response.
  always_comb begin
    occ_after  = flush_younger ? 2'd0 : (buf_count + {1'b0, push} - {1'b0, pop});
    free_after = (state_q == StIdle) || ack;
    issue      = free_after && (occ_after <= 2'd1);
  end

  // FSM and fetch-address next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StIdle;
      StBusy: begin
        if (ack) begin
          state_d = StIdle;
        end else if (flush_younger) begin
          state_d = StDrop;
        end
      end
      StDrop: if (ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (issue) state_d = StBusy;

    req_d        = (state_d != StIdle);
    addr_d       = issue ? fpc_eff : addr_q;
    fetch_pc_d   = fpc_eff;
    pend_valid_d = pend_valid_eff;
    pend_addr_d  = pend_addr_eff;
    if (issue) begin
      fetch_pc_d   = pend_valid_eff ? pend_addr_eff : fpc_eff + 32'd4;
      pend_valid_d = 1'b0;
    end
  end

  // State and registered memory-port outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      addr_q       <= '0;
      fetch_pc_q   <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  if_fetch_buffer u_buffer (
    .clk_i          (clk),
    .rst_i          (rst),
    .push_i         (push),
    .push_pc_i      (addr_q),
    .push_instr_i   (imem_rdata),
    .pop_i          (pop),
    .flush_younger_i(flush_younger),
    .count_o        (buf_count),
    .head_pc_o      (PC_IF),
    .head_instr_o   (instr_IF)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable memory model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_ID;
  logic        branch_jump;
  logic [31:0] bj_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_IF;
  logic [31:0] PC_IF;
  logic        valid_IF;

  int          mem_lat;
  logic        stray_ack;
  logic [31:0] issued [$];
  logic [31:0] deliv  [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall_ID   (stall_ID),
    .branch_jump(branch_jump),
    .bj_address (bj_address),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_IF   (instr_IF),
    .PC_IF      (PC_IF),
    .valid_IF   (valid_IF)
  );

  // Memory: ack in the mem_lat-th cycle of a request; word = addr + 0x1000_0000.
  initial begin : mem_model
    int cnt;
    cnt        = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      if (stray_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cnt        = 0;
      end else if (imem_req) begin
        cnt++;
        if (cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr + 32'h1000_0000;
          cnt        = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Log every newly issued request and every instruction handed to ID.
  initial begin : monitor
    logic prev_req, prev_ack;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && imem_req && (!prev_req || prev_ack)) issued.push_back(imem_addr);
      if (!rst && valid_IF && !stall_ID) deliv.push_back(PC_IF);
      prev_req = imem_req;
      prev_ack = imem_ack;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #4;
    end
  endtask

  // Two reset cycles; checks the reset state, then releases rst for the next edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    step(2);
    check_eq({tag, "_rst_req"},   {31'h0, imem_req}, 32'h0);
    check_eq({tag, "_rst_addr"},  imem_addr, 32'h0);
    check_eq({tag, "_rst_valid"}, {31'h0, valid_IF}, 32'h0);
    check_eq({tag, "_rst_instr"}, instr_IF, 32'h0);
    check_eq({tag, "_rst_pc"},    PC_IF, 32'h0);
    issued.delete();
    deliv.delete();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    stall_ID    = 1'b0;
    branch_jump = 1'b0;
    bj_address  = 32'h0;
    mem_lat     = 1;
    stray_ack   = 1'b0;

    // Zero-wait streaming.
    do_reset("t1");
    step(1);
    check_eq("t1_req0",   {31'h0, imem_req}, 32'h1);
    check_eq("t1_addr0",  imem_addr, 32'h3000);
    check_eq("t1_valid0", {31'h0, valid_IF}, 32'h0);
    check_eq("t1_nop0",   instr_IF, 32'h0);
    step(1);
    check_eq("t1_addr1",  imem_addr, 32'h3004);
    check_eq("t1_valid1", {31'h0, valid_IF}, 32'h1);
    check_eq("t1_pc1",    PC_IF, 32'h3000);
    check_eq("t1_instr1", instr_IF, 32'h1000_3000);
    step(1);
    check_eq("t1_addr2",  imem_addr, 32'h3008);
    check_eq("t1_pc2",    PC_IF, 32'h3004);

    // Stall fills the buffer; release drains it in order.
    stall_ID = 1'b1;
    do_reset("t2");
    step(6);
    check_eq("t2_req_full", {31'h0, imem_req}, 32'h0);
    check_eq("t2_pc_full",  PC_IF, 32'h3000);
    check_eq("t2_iss_n",    32'(issued.size()), 32'd2);
    stall_ID = 1'b0;
    step(1);
    check_eq("t2_pc1",   PC_IF, 32'h3004);
    check_eq("t2_addr1", imem_addr, 32'h3008);
    check_eq("t2_req1",  {31'h0, imem_req}, 32'h1);
    step(1);
    check_eq("t2_pc2",   PC_IF, 32'h3008);
    check_eq("t2_del_n", 32'(deliv.size()), 32'd2);
    check_eq("t2_del0",  q_at(deliv, 0), 32'h3000);
    check_eq("t2_del1",  q_at(deliv, 1), 32'h3004);

    // Redirect with buffer holding 0x3004, 0x3008.
    stall_ID = 1'b1;
    do_reset("t3");
    step(6);
    stall_ID = 1'b0;
    step(1);
    stall_ID = 1'b1;
    step(1);
    check_eq("t3_req_full", {31'h0, imem_req}, 32'h0);
    check_eq("t3_head",     PC_IF, 32'h3004);
    stall_ID    = 1'b0;
    branch_jump = 1'b1;
    bj_address  = 32'h4000;
    step(1);
    branch_jump = 1'b0;
    check_eq("t3_tgt_addr", imem_addr, 32'h4000);
    check_eq("t3_tgt_req",  {31'h0, imem_req}, 32'h1);
    check_eq("t3_flushed",  {31'h0, valid_IF}, 32'h0);
    step(1);
    check_eq("t3_pc_tgt",    PC_IF, 32'h4000);
    check_eq("t3_instr_tgt", instr_IF, 32'h1000_4000);
    check_eq("t3_del_n",     32'(deliv.size()), 32'd2);
    check_eq("t3_del1",      q_at(deliv, 1), 32'h3004);
    check_eq("t3_iss_n",     32'(issued.size()), 32'd4);
    check_eq("t3_iss3",      q_at(issued, 3), 32'h4000);

    // Redirect with head buffered and next word in flight (dropped), target 0x4003.
    mem_lat = 3;
    do_reset("t4");
    step(3);
    check_eq("t4_addr0",  imem_addr, 32'h3000);
    check_eq("t4_valid0", {31'h0, valid_IF}, 32'h0);
    step(1);
    check_eq("t4_head",   PC_IF, 32'h3000);
    check_eq("t4_addr1",  imem_addr, 32'h3004);
    branch_jump = 1'b1;
    bj_address  = 32'h4003;
    step(1);
    branch_jump = 1'b0;
    check_eq("t4_drop_valid", {31'h0, valid_IF}, 32'h0);
    check_eq("t4_drop_addr",  imem_addr, 32'h3004);
    step(2);
    check_eq("t4_tgt_addr",  imem_addr, 32'h4000);
    check_eq("t4_tgt_valid", {31'h0, valid_IF}, 32'h0);
    step(3);
    check_eq("t4_pc_tgt", PC_IF, 32'h4000);
    check_eq("t4_iss_n",  32'(issued.size()), 32'd3);
    check_eq("t4_iss2",   q_at(issued, 2), 32'h4000);

    // Redirect with empty buffer while the delay slot is in flight.
    do_reset("t5");
    step(5);
    check_eq("t5_empty", {31'h0, valid_IF}, 32'h0);
    check_eq("t5_addr1", imem_addr, 32'h3004);
    branch_jump = 1'b1;
    bj_address  = 32'h4000;
    step(1);
    branch_jump = 1'b0;
    check_eq("t5_hold_addr", imem_addr, 32'h3004);
    step(1);
    check_eq("t5_slot_pc",    PC_IF, 32'h3004);
    check_eq("t5_slot_instr", instr_IF, 32'h1000_3004);
    check_eq("t5_tgt_addr",   imem_addr, 32'h4000);
    step(1);
    check_eq("t5_iss_n", 32'(issued.size()), 32'd3);
    check_eq("t5_iss1",  q_at(issued, 1), 32'h3004);
    check_eq("t5_iss2",  q_at(issued, 2), 32'h4000);

    // Reset mid-request with a stray late ack.
    do_reset("t6");
    step(2);
    check_eq("t6_busy_req", {31'h0, imem_req}, 32'h1);
    rst       = 1'b1;
    stray_ack = 1'b1;
    step(1);
    stray_ack = 1'b0;
    check_eq("t6_req_drop",  {31'h0, imem_req}, 32'h0);
    check_eq("t6_addr_drop", imem_addr, 32'h0);
    rst = 1'b0;
    step(1);
    check_eq("t6_re_req",  {31'h0, imem_req}, 32'h1);
    check_eq("t6_re_addr", imem_addr, 32'h3000);
    check_eq("t6_valid_a", {31'h0, valid_IF}, 32'h0);
    step(2);
    check_eq("t6_valid_b", {31'h0, valid_IF}, 32'h0);
    step(1);
    check_eq("t6_pc",    PC_IF, 32'h3000);
    check_eq("t6_instr", instr_IF, 32'h1000_3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
